// File: rtl/cacheline_adapter.sv
// cacheline_adapter: splits one 256-bit cache-line read/writeback into eight 32-bit memory word beats.
//   clk, rst (sync, active-low)       : clock and reset
//   line_address/read/write/wdata     : cache-side line request
//   line_rdata, line_resp             : assembled line and one-cycle completion pulse
//   mem_address/read/write/wdata      : word-wide memory request for the current beat
//   mem_rdata, mem_resp               : memory word return and per-beat completion
//   error                             : sticky flag, set when read and write are requested together
module cacheline_adapter #(
  parameter int S_OFFSET = 5,
  parameter int S_WORD   = 32,
  parameter int S_LINE   = 8 * 2**S_OFFSET,
  parameter int N_BEATS  = S_LINE / S_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       line_address,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [S_LINE-1:0] line_wdata,
  output logic [S_LINE-1:0] line_rdata,
  output logic              line_resp,
  output logic [31:0]       mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [S_WORD-1:0] mem_wdata,
  input  logic [S_WORD-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              error
);
  localparam int BW = $clog2(N_BEATS);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3;
  logic [1:0]                          r_state;
  logic [BW-1:0]                       r_beat;
  logic [31-S_OFFSET:0]                r_addr;
  logic [N_BEATS-1:0][S_WORD-1:0]      r_buf;
  logic                                r_error;
  logic                                w_last;
  logic                                w_unused;
  assign w_last      = r_beat == BW'(N_BEATS - 1);
  assign w_unused    = &{1'b0, line_address[S_OFFSET-1:0]};
  assign mem_read    = r_state == RD;
  assign mem_write   = r_state == WR;
  assign line_resp   = r_state == DONE;
  assign mem_address = {r_addr, r_beat, 2'b00};
  assign mem_wdata   = r_buf[r_beat];
  assign line_rdata  = r_buf;
  assign error       = r_error;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
      r_buf   <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_beat <= '0;
          if (line_write) begin
            // write wins a simultaneous request; the collision is recorded in error
            r_state <= WR;
            r_addr  <= line_address[31:S_OFFSET];
            r_buf   <= line_wdata;
            r_error <= r_error | line_read;
          end else if (line_read) begin
            r_state <= RD;
            r_addr  <= line_address[31:S_OFFSET];
          end
        end
        RD, WR: if (mem_resp) begin
          if (r_state == RD) r_buf[r_beat] <= mem_rdata;
          r_beat <= r_beat + BW'(1);
          if (w_last) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: randomized line transactions checked cycle by cycle against a transaction-level model.
module tb_cacheline_adapter;
  logic         clk = 0, rst = 0, line_read = 0, line_write = 0, mem_resp = 0;
  logic [31:0]  line_address = 0, mem_rdata = 0;
  logic [255:0] line_wdata = 0;
  logic [255:0] line_rdata;
  logic         line_resp, mem_read, mem_write, error;
  logic [31:0]  mem_address, mem_wdata;
  int           errors = 0, checks = 0, cyc_n = 0, acc_cyc = 0, resp_cyc = 0, resp_cnt = 0;
  bit           m_err = 0;
  logic [31:0]  first_addr = 0;
  logic [255:0] last_rdata = 0;
  typedef struct {
    bit           chk, full, rd, wr, resp;
    logic [31:0]  addr, wdata;
    logic [255:0] rdata;
  } exp_t;
  cacheline_adapter dut (
    .clk(clk), .rst(rst), .line_address(line_address), .line_read(line_read),
    .line_write(line_write), .line_wdata(line_wdata), .line_rdata(line_rdata),
    .line_resp(line_resp), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .error(error)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(bit rd, bit wr, bit resp, logic [31:0] a, logic [31:0] wd, logic [255:0] rdv, bit full);
    exp_t e;
    e.chk = 1; e.full = full; e.rd = rd; e.wr = wr; e.resp = resp;
    e.addr = a; e.wdata = wd; e.rdata = rdv;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // one cycle: compare the outputs mid-cycle, record observations, then advance past the edge
  task automatic step(input exp_t e);
    logic [31:0]  a_act, w_act;
    logic [255:0] r_act;
    @(negedge clk);
    if (e.chk) begin
      a_act = (e.full || e.rd || e.wr) ? mem_address : e.addr;
      w_act = (e.full || e.wr) ? mem_wdata : e.wdata;
      r_act = (e.full || e.resp) ? line_rdata : e.rdata;
      checks++;
      if ({mem_read, mem_write, line_resp, error, a_act, w_act, r_act} !==
          {e.rd, e.wr, e.resp, m_err, e.addr, e.wdata, e.rdata}) begin
        errors++;
        $display("FAIL cycle%0d: got rd=%b wr=%b resp=%b err=%b addr=%h wdata=%h rdata=%h expected rd=%b wr=%b resp=%b err=%b addr=%h wdata=%h rdata=%h",
                 cyc_n, mem_read, mem_write, line_resp, error, a_act, w_act, r_act,
                 e.rd, e.wr, e.resp, m_err, e.addr, e.wdata, e.rdata);
      end
    end
    if (line_resp === 1'b1) begin
      resp_cnt++;
      resp_cyc = cyc_n;
      last_rdata = line_rdata;
    end
    if (cyc_n == acc_cyc + 1) first_addr = mem_address;
    cyc_n++;
    @(posedge clk);
    #1;
  endtask
  task automatic rnd_req();
    line_read = 1'($urandom);
    line_write = 1'($urandom);
    line_address = $urandom;
    for (int i = 0; i < 8; i++) line_wdata[32*i +: 32] = $urandom;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      line_read = 0; line_write = 0;
      mem_resp = 1'($urandom); mem_rdata = $urandom;
      step(mk(0, 0, 0, 0, 0, 0, 0));
    end
  endtask
  // wmode < 0: random 0..3 wait cycles per beat; otherwise that fixed number of waits
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] l,
                     input int wmode, input bit pat, input int abort_at);
    logic [255:0] got = '0;
    logic [31:0]  wd;
    int           w;
    rst = 1;
    line_read = rd; line_write = wr; line_address = a; line_wdata = l;
    mem_resp = 1'($urandom); mem_rdata = $urandom;
    acc_cyc = cyc_n;
    step(mk(0, 0, 0, 0, 0, 0, 0));
    m_err = m_err | (rd & wr);
    for (int k = 0; k < 8; k++) begin
      wd = wr ? l[32*k +: 32] : 32'h0;
      if (k == abort_at) begin
        rnd_req(); mem_resp = 0; rst = 0;
        step(mk(!wr, wr, 0, (a & ~32'h1f) + 32'(4*k), wd, 0, 0));
        m_err = 0;
        rst = 1; line_read = 0; line_write = 0;
        step(mk(0, 0, 0, 0, 0, 0, 1));
        return;
      end
      w = wmode < 0 ? int'($urandom_range(0, 3)) : wmode;
      for (int j = 0; j <= w; j++) begin
        rnd_req();
        mem_resp = (j == w);
        mem_rdata = pat ? 32'hA000_0000 + 32'(k) : $urandom;
        if (j == w) got[32*k +: 32] = mem_rdata;
        step(mk(!wr, wr, 0, (a & ~32'h1f) + 32'(4*k), wd, 0, 0));
      end
    end
    line_read = rd; line_write = wr; mem_resp = 1'($urandom);
    step(mk(0, 0, 1, 0, 0, wr ? l : got, 0));
  endtask
  initial begin
    logic [255:0] l;
    int snap, r, t0;
    rst = 0; line_read = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 1));
    txn(1, 0, 32'h0000_1234, 0, 0, 1, 8);
    chk("zw_first_addr", 256'(first_addr), 256'h1220);
    chk("zw_latency", 256'(resp_cyc - acc_cyc), 256'd9);
    chk("zw_word3", 256'(last_rdata[127:96]), 256'hA000_0003);
    chk("zw_word7", 256'(last_rdata[255:224]), 256'hA000_0007);
    idle(2);
    for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'h1111_1111 * 32'(k);
    t0 = cyc_n;
    txn(0, 1, 32'h0000_4440, l, 2, 0, 8);
    chk("ws_echo_word5", 256'(last_rdata[191:160]), 256'h5555_5555);
    chk("ws_latency", 256'(resp_cyc - t0), 256'd25);
    chk("ws_error_clear", 256'(error), 256'd0);
    idle(1);
    txn(1, 1, $urandom, {8{$urandom}}, -1, 0, 8);
    chk("both_error_set", 256'(error), 256'd1);
    txn(1, 0, $urandom, 0, -1, 0, 8);
    chk("both_error_sticky", 256'(error), 256'd1);
    idle(1);
    snap = resp_cnt;
    txn(1, 0, 32'h0000_7700, 0, -1, 0, 5);
    chk("abort_no_resp", 256'(resp_cnt), 256'(snap));
    chk("abort_error_cleared", 256'(error), 256'd0);
    txn(1, 0, 32'h0000_ABFF, 0, -1, 0, 8);
    chk("abort_restart_addr", 256'(first_addr), 256'hABE0);
    snap = resp_cnt;
    txn(1, 0, $urandom, 0, -1, 0, 8);
    t0 = resp_cyc;
    txn(1, 0, $urandom, 0, 0, 0, 8);
    chk("b2b_two_resps", 256'(resp_cnt - snap), 256'd2);
    chk("b2b_gap", 256'(resp_cyc - t0), 256'd10);
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
      txn(r < 5 || r == 9, r >= 5, $urandom, l, $urandom_range(0, 1) ? -1 : 0, 0,
          $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 7)) : 8);
      idle($urandom_range(0, 2));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Sits directly downstream of the 2-way set-associative cache, on its memory-side (controller) interface.
- Converts one 256-bit cache-line read or writeback into a burst of eight 32-bit word transactions on the word-wide main-memory bus.
- Returns the assembled line to the cache with a single-cycle line response.
- Handles all per-word handshaking and variable memory latency so the cache sees one line transaction.

Parameters:
- S_OFFSET, 5, line offset bits; line = 2**S_OFFSET bytes (32).
- S_WORD, 32, memory word width in bits.
- S_LINE, 8*2**S_OFFSET, line width in bits (256).
- N_BEATS, S_LINE/S_WORD, words per line (8); beat counter is $clog2(N_BEATS) bits.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- line_address  in  32  cache-side line address; bits [S_OFFSET-1:0] ignored.
- line_read  in  1  cache requests a line fill.
- line_write  in  1  cache requests a line writeback.
- line_wdata  in  S_LINE  writeback line; word k = bits [32k+31:32k].
- line_rdata  out  S_LINE  filled line, valid while line_resp=1.
- line_resp  out  1  one-cycle completion pulse to cache.
- mem_address  out  32  word address = {addr_q[31:S_OFFSET], beat, 2'b00}.
- mem_read  out  1  word read request.
- mem_write  out  1  word write request.
- mem_wdata  out  S_WORD  current beat's write word.
- mem_rdata  in  S_WORD  word returned by memory, valid with mem_resp.
- mem_resp  in  1  memory completed current word.
- error  out  1  sticky protocol-error flag.

Behaviour:
- States: IDLE, RD, WR, DONE.
- Reset (rst=0 at an edge, from any state): state=IDLE, beat=0, addr_q=0, line buffer=0, error=0. After that edge: line_resp=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, line_rdata=0.
- Reset mid-burst: abandons the burst with no line_resp. The memory request drops at the same edge.
- IDLE:
  - line_write=1: capture line_address into addr_q and line_wdata into the buffer, beat=0, go to WR.
  - else line_read=1: capture address, beat=0, go to RD.
  - Both high together: take WR (write priority) and set error=1.
  - Neither high: stay in IDLE.
- RD:
  - mem_read=1 continuously; mem_address tracks beat.
  - On each edge with mem_resp=1: buffer word[beat] <= mem_rdata, beat+1.
  - mem_resp with beat=N_BEATS-1: beat wraps to 0, go to DONE.
  - mem_resp=0: hold all state; no timeout.
- WR:
  - mem_write=1; mem_wdata = buffer word[beat].
  - Beat advance and exit to DONE are the same as RD.
  - Buffer is not modified.
- DONE:
  - line_resp=1 for exactly this one cycle; mem_read and mem_write are 0.
  - line_rdata = buffer: the full fill after a read, the echoed line after a write.
  - Unconditional transition to IDLE.
- Requester rule: the cache must sample line_resp and deassert its request so the request is low in the cycle after DONE. A request still high in IDLE starts a new transaction; this is legal back-to-back operation.
- Inputs during RD/WR/DONE: line_address, line_wdata, line_read and line_write are ignored (captured values only).
- mem_resp outside RD/WR: ignored.
- Zero-wait memory: mem_resp=1 in the first cycle of RD/WR is legal.
- Minimum line latency: request accepted at edge 0; line_resp high in cycle N_BEATS+1 (10 cycles total incl. DONE). Each memory wait cycle adds one cycle.
- mem_read and mem_write are never both 1.
- mem_address is always word-aligned.
- error: cleared only by reset.

Test Plan:
- Reset hold: rst=0 for 3 cycles with line_read=1 -> all outputs 0, no mem_read. Release -> mem_read=1 next cycle.
- Zero-wait read: line_address=0x0000_1234, mem_resp tied 1, mem_rdata=0xA000_0000+beat.
  - mem_address steps 0x1220,0x1224,…,0x123C.
  - line_resp one cycle, 9 cycles after accept; line_rdata word k = 0xA000_000k.
- Wait-state write: line_wdata word k = 0x1111_1111*k; mem_resp asserted every 3rd cycle.
  - mem_write held high.
  - mem_wdata changes only after each resp.
  - 8 word writes; line_resp after the 8th resp.
  - error stays 0.
- Simultaneous request: line_read=line_write=1 in IDLE -> write burst performed (mem_write, never mem_read); error=1 and stays 1 through a following clean read.
- Mid-burst reset: rst=0 after beat 4 of a read -> mem_read=0 the next cycle, no line_resp. A new read after release starts at beat 0 (mem_address offset 0x00).
- Back-to-back: line_read held high across line_resp -> second fill starts in the IDLE cycle after DONE; two distinct line_resp pulses, gap of ≥1 cycle.
